// File: rtl/sprite_line_renderer_pkg.sv
// Shared constants, sprite register layout and FSM state encoding for sprite_line_renderer.
package sprite_pkg;

    localparam int NSPRITES    = 8;
    localparam int SPR_DIM     = 32;
    localparam int HPIX        = 320;
    localparam int VACTIVE     = 480;
    localparam int VTOTAL      = 525;
    localparam int HACTIVE_CLK = 1280;

    // Avalon word address field selectors (address[1:0]); address[5:3] picks the slot
    localparam logic [1:0] FIELD_X    = 2'd0;
    localparam logic [1:0] FIELD_Y    = 2'd1;
    localparam logic [1:0] FIELD_CTRL = 2'd2;
    localparam int         CTRL_EN_BIT = 5;

    typedef struct packed {
        logic       en;
        logic [4:0] img;
        logic [9:0] x;
        logic [9:0] y;
    } sprite_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_FETCH,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/sprite_line_renderer_if.sv
// Avalon-MM write-only slave bus carrying HPS sprite register writes.
interface sprite_line_renderer_if;
    logic [15:0] writedata;
    logic        write;
    logic        chipselect;
    logic [5:0]  address;

    modport master (output writedata, write, chipselect, address);
    modport slave  (input  writedata, write, chipselect, address);
endinterface

// File: rtl/sprite_line_renderer_line_buf.sv
// Ping-pong pair of 320x4 line buffers: one write port, one registered read port (M10K-friendly).
module line_buf
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic       wr_bank,
    input  logic [8:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       rd_bank,
    input  logic [8:0] rd_addr,
    output logic [3:0] rd_data
);
    logic [3:0] mem [2][HPIX];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_bank][wr_addr] <= wr_data;
        rd_data <= mem[rd_bank][rd_addr];
    end
endmodule

// File: rtl/sprite_line_renderer.sv
// Renders up to 8 sprites into ping-pong line buffers one line ahead of the display.
// Optional macro SPRITE_SHADOW_EN: renderer reads shadow registers captured at the start of vblank.
module sprite_line_renderer
    import sprite_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    sprite_line_renderer_if.slave bus,
    input  logic [10:0]           hcount,
    input  logic [9:0]            vcount,
    output logic [14:0]           rom_addr,
    input  logic [3:0]            rom_q,
    output logic [3:0]            pix_color,
    output logic                  pix_valid
);
    sprite_t     live [NSPRITES];
    sprite_t     cur;
    state_t      state, next_state;
    logic [2:0]  slot, wr_slot;
    logic [8:0]  clr_cnt, buf_waddr;
    logic [4:0]  col, spr_img, spr_row;
    logic [9:0]  spr_x, tline, tgt, row_calc;
    logic [10:0] iss_pos, ret_pos;
    logic [3:0]  buf_wdata, rd_data;
    logic        wbank, start, hit, iss_v, ret_v, buf_we, rd_active, rd_active_q;
    logic        unused_bits;

    assign wr_slot     = bus.address[5:3];
    assign unused_bits = ^{bus.writedata[15:10], bus.address[2]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSPRITES; i++) live[i] <= '0;
        end else if (bus.chipselect && bus.write) begin
            case (bus.address[1:0])
                FIELD_X:    live[wr_slot].x <= bus.writedata[9:0];
                FIELD_Y:    live[wr_slot].y <= bus.writedata[9:0];
                FIELD_CTRL: begin
                    live[wr_slot].en  <= bus.writedata[CTRL_EN_BIT];
                    live[wr_slot].img <= bus.writedata[4:0];
                end
                default: ;
            endcase
        end
    end

`ifdef SPRITE_SHADOW_EN
    sprite_t shadow [NSPRITES];

    // Snapshot samples live before any same-cycle write lands, so that write waits a frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSPRITES; i++) shadow[i] <= '0;
        end else if (hcount == 11'd0 && vcount == 10'(VACTIVE)) begin
            for (int i = 0; i < NSPRITES; i++) shadow[i] <= live[i];
        end
    end

    assign cur = shadow[slot];
`else
    assign cur = live[slot];
`endif

    assign tgt      = (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    assign start    = (hcount == 11'd0) && (tgt < 10'(VACTIVE));
    assign row_calc = tline - cur.y;
    assign hit      = cur.en && (row_calc < 10'(SPR_DIM));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_CLEAR;
            ST_CLEAR: if (clr_cnt == 9'(HPIX - 1)) next_state = ST_SCAN;
            ST_SCAN: begin
                if (hit)              next_state = ST_FETCH;
                else if (slot == 3'd0) next_state = ST_IDLE;
            end
            ST_FETCH: if (col == 5'(SPR_DIM - 1)) next_state = ST_DRAIN;
            ST_DRAIN: next_state = (slot == 3'd0) ? ST_IDLE : ST_SCAN;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Fetch pipeline carries the screen column with each ROM request so a later sprite can latch freely
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tline    <= '0;
            wbank    <= 1'b0;
            clr_cnt  <= '0;
            slot     <= '0;
            col      <= '0;
            spr_x    <= '0;
            spr_img  <= '0;
            spr_row  <= '0;
            rom_addr <= '0;
            iss_v    <= 1'b0;
            iss_pos  <= '0;
            ret_v    <= 1'b0;
            ret_pos  <= '0;
        end else begin
            iss_v   <= (state == ST_FETCH);
            ret_v   <= iss_v;
            ret_pos <= iss_pos;
            case (state)
                ST_IDLE: if (start) begin
                    tline   <= tgt;
                    wbank   <= tgt[0];
                    clr_cnt <= '0;
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 9'd1;
                    slot    <= 3'(NSPRITES - 1);
                end
                ST_SCAN: begin
                    if (hit) begin
                        spr_x   <= cur.x;
                        spr_img <= cur.img;
                        spr_row <= row_calc[4:0];
                        col     <= '0;
                    end else begin
                        slot <= slot - 3'd1;
                    end
                end
                ST_FETCH: begin
                    rom_addr <= {spr_img, spr_row, col};
                    iss_pos  <= {1'b0, spr_x} + {6'd0, col};
                    col      <= col + 5'd1;
                end
                ST_DRAIN: slot <= slot - 3'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = ret_pos[8:0];
        buf_wdata = rom_q;
        if (state == ST_CLEAR) begin
            buf_we    = 1'b1;
            buf_waddr = clr_cnt;
            buf_wdata = 4'd0;
        end else if (ret_v && rom_q != 4'd0 && ret_pos < 11'(HPIX)) begin
            buf_we = 1'b1;
        end
    end

    // Columns past the 320-wide buffer and all blanking read as transparent
    assign rd_active = (hcount < 11'(HACTIVE_CLK)) && (hcount[10:1] < 10'(HPIX))
                       && (vcount < 10'(VACTIVE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_active_q <= 1'b0;
        else          rd_active_q <= rd_active;
    end

    line_buf u_line_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_bank (wbank),
        .wr_addr (buf_waddr),
        .wr_data (buf_wdata),
        .rd_bank (vcount[0]),
        .rd_addr (hcount[9:1]),
        .rd_data (rd_data)
    );

    assign pix_color = rd_active_q ? rd_data : 4'd0;
    assign pix_valid = (pix_color != 4'd0);
endmodule
